// File: rtl/cmp_share_arbiter_if.sv
`default_nettype none
// ====================================================================
// cmp_share_arbiter_if: requester/response bundle for cmp_share_arbiter
// Rev 1.0
// ====================================================================
interface cmp_share_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_diff;
  logic                  resp_ge;
  logic                  resp_eq;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_diff, resp_ge, resp_eq
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_diff, resp_ge, resp_eq
  );
endinterface
`default_nettype wire

// File: rtl/cmp_share_arbiter.sv
`default_nettype none
// ====================================================================
// cmp_share_arbiter: round-robin sharing of one A+~B+1 subtract/compare chain
// Rev 1.0
// ====================================================================
module cmp_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                clk,
  input  logic                rst,
  cmp_share_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt;
  logic [IDW-1:0]   scan_idx;
  logic             any_req;
  logic             slot_free;
  logic             xfer;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum;
  logic [IDW-1:0]   resp_id_q;
  logic [WIDTH-1:0] resp_diff_q;
  logic             resp_ge_q;
  logic             resp_eq_q;

  // Scan from the farthest offset down so the one nearest ptr wins last.
  always_comb begin
    any_req  = 1'b0;
    gnt      = '0;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = ptr + IDW'(k);
      if (bus.req_valid[scan_idx]) begin
        any_req = 1'b1;
        gnt     = scan_idx;
      end
    end
  end

  assign slot_free     = (state == EMPTY) || bus.resp_ready;
  assign xfer          = slot_free && any_req && !rst;
  assign bus.req_ready = xfer ? (NREQ'(1) << gnt) : '0;

  // The single shared carry chain: A + ~B + 1, carry-out means A >= B.
  assign a_sel = bus.req_a[gnt*WIDTH +: WIDTH];
  assign b_sel = bus.req_b[gnt*WIDTH +: WIDTH];
  assign sum   = {1'b0, a_sel} + {1'b0, ~b_sel} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (xfer) state_nxt = FULL;
      FULL:  if (bus.resp_ready && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      resp_id_q   <= '0;
      resp_diff_q <= '0;
      resp_ge_q   <= 1'b0;
      resp_eq_q   <= 1'b0;
    end else if (xfer) begin
      ptr         <= gnt + IDW'(1);
      resp_id_q   <= gnt;
      resp_diff_q <= sum[WIDTH-1:0];
      resp_ge_q   <= sum[WIDTH];
      resp_eq_q   <= (sum[WIDTH-1:0] == '0);
    end
  end

  assign bus.resp_valid = (state == FULL);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_diff  = resp_diff_q;
  assign bus.resp_ge    = resp_ge_q;
  assign bus.resp_eq    = resp_eq_q;

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.req_ready));

  a_resp_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.resp_valid && !bus.resp_ready) |=>
      (bus.resp_valid && $stable(bus.resp_id) && $stable(bus.resp_diff)
       && $stable(bus.resp_ge) && $stable(bus.resp_eq)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_share_arbiter.sv
`default_nettype none
// ====================================================================
// tb_cmp_share_arbiter: vector table, directed corner sequences, random vs model
// Rev 1.0
// ====================================================================
module tb_cmp_share_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  cmp_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int id;
    int a;
    int b;
    int diff;
    int ge;
    int eq;
  } vec_t;

  vec_t vt[8];

  // random-phase reference state
  int m_ptr;
  bit m_valid;
  int m_id, m_diff, m_ge, m_eq;
  bit [NREQ-1:0] rv;
  int ra[NREQ];
  int rb[NREQ];
  int last_g;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string name, input int id, input int diff, input int ge, input int eq);
    chk({name, "_valid"}, int'(bus.resp_valid), 1);
    chk({name, "_id"},    int'(bus.resp_id), id);
    chk({name, "_diff"},  int'(bus.resp_diff), diff);
    chk({name, "_ge"},    int'(bus.resp_ge), ge);
    chk({name, "_eq"},    int'(bus.resp_eq), eq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int exp_rr;
    bit rdy;

    vt[0] = '{0, 3, 5, 14, 0, 0};
    vt[1] = '{0, 9, 9, 0, 1, 1};
    vt[2] = '{0, 0, 15, 1, 0, 0};
    vt[3] = '{1, 15, 0, 15, 1, 0};
    vt[4] = '{2, 7, 8, 15, 0, 0};
    vt[5] = '{1, 8, 7, 1, 1, 0};
    vt[6] = '{2, 12, 12, 0, 1, 1};
    vt[7] = '{3, 6, 1, 5, 1, 0};

    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    // reset state
    #12;
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_req_ready",  int'(bus.req_ready), 0);
    chk("rst_resp_id",    int'(bus.resp_id), 0);
    chk("rst_resp_diff",  int'(bus.resp_diff), 0);
    chk("rst_resp_ge",    int'(bus.resp_ge), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // first transfer from requester 2; next grant from ptr=3 must be 3
    set_op(2, 5, 3);
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b1;
    #1 chk("first_grant", int'(bus.req_ready), 4);
    step();
    chk_resp("first_resp", 2, 2, 1, 0);
    set_op(0, 1, 1);
    set_op(3, 4, 4);
    bus.req_valid = 4'b1001;
    #1 chk("ptr_after_first", int'(bus.req_ready), 8);
    step();
    chk_resp("ptr3_resp", 3, 0, 1, 1);

    // table of single-requester operand pairs
    for (int i = 0; i < 8; i++) begin
      set_op(vt[i].id, vt[i].a, vt[i].b);
      bus.req_valid = NREQ'(1 << vt[i].id);
      #1 chk("tbl_grant", int'(bus.req_ready), 1 << vt[i].id);
      step();
      chk_resp("tbl", vt[i].id, vt[i].diff, vt[i].ge, vt[i].eq);
    end

    // consume with no new transfer: valid drops, data holds
    bus.req_valid = '0;
    step();
    chk("consume_valid", int'(bus.resp_valid), 0);
    chk("consume_diff_hold", int'(bus.resp_diff), 5);

    // all requesting from ptr=0
    set_op(0, 9, 2);
    set_op(1, 1, 1);
    set_op(2, 1, 1);
    set_op(3, 1, 1);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_grant", int'(bus.req_ready), 1 << (k % 4));
      step();
      chk("rr_id", int'(bus.resp_id), k % 4);
      chk("rr_valid", int'(bus.resp_valid), 1);
    end

    // backpressure for 3 cycles
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", int'(bus.req_ready), 0);
      step();
      chk_resp("bp_hold", 0, 7, 1, 0);
    end
    bus.resp_ready = 1'b1;
    #1 chk("bp_release_grant", int'(bus.req_ready), 2);
    step();
    chk("bp_release_id", int'(bus.resp_id), 1);

    // ptr=2: requester 0 shows briefly under backpressure, then drops
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b1011;
    #1 chk("drop_blocked", int'(bus.req_ready), 0);
    step();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1 chk("alt_grant", int'(bus.req_ready), (k == 1) ? 2 : 8);
      step();
      chk("alt_id", int'(bus.resp_id), (k == 1) ? 1 : 3);
    end

    // asynchronous reset with a response pending and ptr=2
    set_op(1, 9, 2);
    bus.req_valid = 4'b0010;
    step();
    chk_resp("pre_rst", 1, 7, 1, 0);
    bus.req_valid = 4'b1111;
    #1 chk("pre_rst_grant", int'(bus.req_ready), 4);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid",     int'(bus.resp_valid), 0);
    chk("arst_diff",      int'(bus.resp_diff), 0);
    chk("arst_id",        int'(bus.resp_id), 0);
    chk("arst_ge",        int'(bus.resp_ge), 0);
    chk("arst_req_ready", int'(bus.req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_grant", int'(bus.req_ready), 1);
    step();
    chk("post_rst_id", int'(bus.resp_id), 0);

    // randomized phase against a reference model, starting from reset
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    m_ptr = 0; m_valid = 0; m_id = 0; m_diff = 0; m_ge = 0; m_eq = 0;
    rv = '0;
    last_g = -1;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 0;
      rb[i] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] || last_g == i) begin
          rv[i] = ($urandom % 3) != 0;
          ra[i] = $urandom_range(0, MASK);
          case ($urandom % 5)
            0:       rb[i] = ra[i];
            1:       rb[i] = ($urandom % 2) ? MASK : 0;
            default: rb[i] = $urandom_range(0, MASK);
          endcase
        end else if ($urandom % 10 == 0) begin
          rv[i] = 1'b0;
        end
        set_op(i, ra[i], rb[i]);
      end
      rdy = ($urandom % 4) != 0;
      bus.req_valid  = rv;
      bus.resp_ready = rdy;

      g = -1;
      if (!m_valid || rdy) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (rv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end
      exp_rr = (g >= 0) ? (1 << g) : 0;

      #1;
      chk("rnd_req_ready",  int'(bus.req_ready), exp_rr);
      chk("rnd_resp_valid", int'(bus.resp_valid), int'(m_valid));
      chk("rnd_resp_id",    int'(bus.resp_id), m_id);
      chk("rnd_resp_diff",  int'(bus.resp_diff), m_diff);
      chk("rnd_resp_ge",    int'(bus.resp_ge), m_ge);
      chk("rnd_resp_eq",    int'(bus.resp_eq), m_eq);

      if (g >= 0) begin
        m_valid = 1'b1;
        m_id    = g;
        m_diff  = (ra[g] - rb[g]) & MASK;
        m_ge    = (ra[g] >= rb[g]) ? 1 : 0;
        m_eq    = (ra[g] == rb[g]) ? 1 : 0;
        m_ptr   = (g + 1) % NREQ;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      last_g = g;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
Round-robin arbiter and sequencer that time-shares one unsigned WIDTH-bit subtract/compare datapath (A + ~B + 1 with carry-out) among NREQ requesters. Each requester posts an operand pair under a valid/ready handshake. The block grants one requester per cycle, computes the difference, the unsigned A>=B flag and the equality flag, and returns a registered response tagged with the requester ID. It sits between multiple compare clients and a single carry-chain subtractor, so the design needs only one adder chain.

Parameters:
WIDTH, 4, operand width in bits (≥1)
NREQ, 4, number of requesters; power of two, 2..8
IDW, log2(NREQ), width of the requester ID (derived, not overridable)

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-high reset
REQ_VALID  input  NREQ  bit i: requester i presents operands
REQ_A  input  NREQ*WIDTH  minuend; requester i in bits [i*WIDTH +: WIDTH]
REQ_B  input  NREQ*WIDTH  subtrahend; same packing as REQ_A
REQ_READY  output  NREQ  one-hot grant; bit i high means requester i transfers this cycle
RESP_VALID  output  1  response register holds a valid result
RESP_READY  input  1  consumer accepts the response this cycle
RESP_ID  output  IDW  index of the requester that produced the response
RESP_DIFF  output  WIDTH  (A − B) mod 2^WIDTH
RESP_GE  output  1  unsigned A ≥ B; equals the carry-out of A + ~B + 1
RESP_EQ  output  1  A == B

Behaviour:
- Reset (asynchronous, any time):
  - RESP_VALID=0, RESP_ID=0, RESP_DIFF=0, RESP_GE=0, RESP_EQ=0.
  - Round-robin pointer PTR=0.
  - REQ_READY=0 while RESET is high.
  - An in-flight response is discarded. Requesters must re-present after reset.
- Slot free: SLOT_FREE = !RESP_VALID || RESP_READY. A consume and a new accept may occur in the same cycle.
- Grant selection (combinational):
  - When SLOT_FREE, the grant G is the first index i with REQ_VALID[i]=1, scanning PTR, PTR+1, … mod NREQ.
  - REQ_READY = onehot(G) when SLOT_FREE and any REQ_VALID is set; otherwise all zeros.
  - REQ_READY never depends on requesters other than through REQ_VALID. At most one bit is set.
- Transfer when REQ_VALID[G] & REQ_READY[G]. On the next rising edge:
  - RESP_VALID←1, RESP_ID←G.
  - RESP_DIFF←A_G + ~B_G + 1 truncated to WIDTH.
  - RESP_GE←carry-out.
  - RESP_EQ←(RESP_DIFF next == 0).
  - PTR←(G+1) mod NREQ.
- Latency: exactly 1 cycle from transfer to RESP_VALID. Throughput is one response per cycle while RESP_READY=1.
- Consume without new transfer (RESP_VALID & RESP_READY, no grant): RESP_VALID←0. Data outputs hold their last value.
- Backpressure (RESP_VALID & !RESP_READY):
  - REQ_READY=0 for all requesters.
  - All RESP_* outputs hold stable.
  - PTR holds.
- Idle (no REQ_VALID): PTR holds. It advances only on a transfer.
- Fairness: a requester that holds REQ_VALID continuously is granted within NREQ transfers.
- Requester obligation: operands must be stable while REQ_VALID is high and not yet granted. A requester may drop REQ_VALID before it is granted; no state is affected.
- Boundaries:
  - A=B → DIFF=0, GE=1, EQ=1.
  - A=0, B=2^WIDTH−1 → DIFF=1, GE=0.
  - A=2^WIDTH−1, B=0 → DIFF=all ones, GE=1.
- Control state machine:
  - EMPTY (RESP_VALID=0): a transfer moves to FULL.
  - FULL: RESP_READY with a transfer stays FULL; RESP_READY without a transfer goes to EMPTY; !RESP_READY stays FULL.

Test Plan:
- Reset, then REQ_VALID=0100, A2=5, B2=3, RESP_READY=1 → REQ_READY=0100 in the same cycle. Next cycle: RESP_VALID=1, RESP_ID=2, DIFF=2, GE=1, EQ=0, and PTR=3.
- Single requester 0 with A=3, B=5 → DIFF=14, GE=0, EQ=0. Then A=9, B=9 → DIFF=0, GE=1, EQ=1. Then A=0, B=15 → DIFF=1, GE=0.
- REQ_VALID=1111 held, RESP_READY=1, from PTR=0 → grants 0,1,2,3,0 on consecutive cycles, RESP_ID sequence 0,1,2,3,0, one response per cycle.
- Response pending with RESP_READY=0 for 3 cycles and REQ_VALID=1111 → REQ_READY=0000, RESP_* unchanged for 3 cycles. Raise RESP_READY → the next grant issues in that same cycle.
- REQ_VALID=1010 with PTR=2 → grant 3, then 1, then 3. Requester 0 deasserting before grant causes no response with ID 0.
- Assert RESET mid-stream with RESP_VALID=1 and PTR=2 → outputs go to 0 asynchronously with no clock edge. After release, the first grant with REQ_VALID=1111 is requester 0.
